// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master external bus arbiter.
// Holds the FSM state encoding, master ids and the read-tag record.
// Pure declarations: no logic, no latency.
package bus_arbiter_pkg;

  // Arbiter ownership states (IDLE=0, OWN0=1, OWN1=2)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Master identifiers
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Read tag carried alongside an outstanding read beat
  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

  // Width of the hold counter; at least one bit so MAX_HOLD=1 still elaborates
  function automatic int hold_cnt_w(input int max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

  // State owned by a given master id
  function automatic arb_state_e own_state(input logic id);
    return (id == M1) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/bus_arbiter_rd_tag_pipe.sv
// Delay line carrying {valid,id} of each read beat until its data returns.
// Latency: exactly RD_LAT cycles from i_tag to o_tag.
// No backpressure: one entry in and one out every cycle; reset empties it.
module rd_tag_pipe
  import bus_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [RD_LAT];

  // Shift tags one stage per cycle; reset drops every in-flight tag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[RD_LAT-1];

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the external data bus, with hold limit and read-data routing.
// Latency: grant 1 cycle after req (registered FSM); owner then beats 1/cycle; read data RD_LAT after beat.
// Backpressure: a master holds req/addr/wr_rd/wdata until granted; read returns cannot be stalled.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  // master 0 (CPU MEM stage)
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wr_rd,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  // master 1 (DMA / debug loader)
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wr_rd,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  // external bus
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_cs,
  output logic              bus_wr_rd,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int HOLD_W = hold_cnt_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        r_state;
  logic              r_last;
  logic [HOLD_W-1:0] r_hold;

  arb_state_e        w_state_nxt;
  logic              w_last_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;

  logic              w_owned;
  logic              w_owner_id;
  logic              w_own_req;
  logic              w_oth_req;

  rd_tag_t           w_tag_in;
  rd_tag_t           w_tag_out;

  // Resolve who owns the bus this cycle and whether each side is asking
  always_comb begin
    w_owned    = 1'b0;
    w_owner_id = M0;
    w_own_req  = 1'b0;
    w_oth_req  = 1'b0;
    case (r_state)
      OWN0: begin
        w_owned    = 1'b1;
        w_owner_id = M0;
        w_own_req  = m0_req;
        w_oth_req  = m1_req;
      end
      OWN1: begin
        w_owned    = 1'b1;
        w_owner_id = M1;
        w_own_req  = m1_req;
        w_oth_req  = m0_req;
      end
      default: begin
        w_owned    = 1'b0;
        w_owner_id = M0;
        w_own_req  = 1'b0;
        w_oth_req  = 1'b0;
      end
    endcase
  end

  // Next ownership: round-robin on ties, hand over after MAX_HOLD contended beats
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE: begin
        w_hold_nxt = '0;
        if (m0_req && m1_req) begin
          // the master not served most recently wins the tie
          w_state_nxt = (r_last == M0) ? OWN1 : OWN0;
        end else if (m0_req) begin
          w_state_nxt = OWN0;
        end else if (m1_req) begin
          w_state_nxt = OWN1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (w_own_req) begin
          if (w_oth_req) begin
            if (r_hold == HOLD_LAST) begin
              // this cycle's beat still completes for the current owner
              w_state_nxt = own_state(~w_owner_id);
              w_hold_nxt  = '0;
              w_last_nxt  = w_owner_id;
            end else begin
              w_hold_nxt = r_hold + HOLD_W'(1);
            end
          end else begin
            // uncontended: owner may stream indefinitely
            w_hold_nxt = '0;
          end
        end else begin
          // owner released (possibly without a beat): pass on or go idle
          w_state_nxt = w_oth_req ? own_state(~w_owner_id) : IDLE;
          w_hold_nxt  = '0;
          w_last_nxt  = w_owner_id;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Arbitration state register; M1 counts as last served so M0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= M1;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign m0_gnt = (r_state == OWN0);
  assign m1_gnt = (r_state == OWN1);

  // Drive the external bus from the owner; everything reads zero when no beat is issued
  always_comb begin
    bus_cs    = w_owned && w_own_req;
    bus_addr  = '0;
    bus_wr_rd = 1'b0;
    bus_wdata = '0;
    if (bus_cs) begin
      if (w_owner_id == M1) begin
        bus_addr  = m1_addr;
        bus_wr_rd = m1_wr_rd;
        bus_wdata = m1_wdata;
      end else begin
        bus_addr  = m0_addr;
        bus_wr_rd = m0_wr_rd;
        bus_wdata = m0_wdata;
      end
    end
  end

  // Every read beat leaves a tag that resurfaces exactly when its data is on bus_rdata
  assign w_tag_in.vld = bus_cs && !bus_wr_rd;
  assign w_tag_in.id  = w_owner_id;

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Route returning read data only to the master that issued the read
  always_comb begin
    m0_rvalid = w_tag_out.vld && (w_tag_out.id == M0);
    m1_rvalid = w_tag_out.vld && (w_tag_out.id == M1);
    m0_rdata  = m0_rvalid ? bus_rdata : '0;
    m1_rdata  = m1_rvalid ? bus_rdata : '0;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 4;
  localparam int RL = 2;
  localparam int NROWS = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m0_wr_rd, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_wr_rd, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] bus_addr;
  logic          bus_cs, bus_wr_rd;
  logic [DW-1:0] bus_wdata, bus_rdata;

  bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr_rd(m0_wr_rd), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr_rd(m1_wr_rd), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .bus_addr(bus_addr), .bus_cs(bus_cs), .bus_wr_rd(bus_wr_rd),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // Memory contents seen by the external bus
  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 32'h200) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
  endfunction

  // External slave: returns read data RL cycles after each read beat, garbage otherwise
  logic          mp_vld  [RL];
  logic [AW-1:0] mp_addr [RL];
  always @(posedge clk) begin
    mp_vld[0]  <= bus_cs && !bus_wr_rd;
    mp_addr[0] <= bus_addr;
    for (int i = 1; i < RL; i++) begin
      mp_vld[i]  <= mp_vld[i-1];
      mp_addr[i] <= mp_addr[i-1];
    end
  end
  assign bus_rdata = (mp_vld[RL-1] === 1'b1) ? mem_data(mp_addr[RL-1]) : 32'hBAD0_0BAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every rvalid must match the oldest expected read of that master
  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_exclusive", {31'b0, m0_gnt & m1_gnt}, 32'h0);
      if (m0_rvalid) begin
        if (q0.size() == 0) chk("m0_rvalid_unexpected", {31'b0, m0_rvalid}, 32'h0);
        else chk("m0_rdata", m0_rdata, q0.pop_front());
      end else begin
        chk("m0_rdata_idle", m0_rdata, 32'h0);
      end
      if (m1_rvalid) begin
        if (q1.size() == 0) chk("m1_rvalid_unexpected", {31'b0, m1_rvalid}, 32'h0);
        else chk("m1_rdata", m1_rdata, q1.pop_front());
      end else begin
        chk("m1_rdata_idle", m1_rdata, 32'h0);
      end
    end
  end

  typedef struct packed {
    logic          rst;
    logic          r0;
    logic          w0;
    logic [AW-1:0] a0;
    logic          r1;
    logic          w1;
    logic [AW-1:0] a1;
    logic          eg0;
    logic          eg1;
    logic          ecs;
  } row_t;

  row_t tbl [NROWS];

  function automatic row_t mk(input logic rs, input logic r0, input logic w0, input logic [31:0] a0,
                              input logic r1, input logic w1, input logic [31:0] a1,
                              input logic eg0, input logic eg1, input logic ecs);
    row_t r;
    r.rst = rs; r.r0 = r0; r.w0 = w0; r.a0 = a0;
    r.r1 = r1; r.w1 = w1; r.a1 = a1;
    r.eg0 = eg0; r.eg1 = eg1; r.ecs = ecs;
    return r;
  endfunction

  task automatic cyc_check(input string tag, input logic eg0, input logic eg1, input logic ecs);
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ed;
    ea = '0; ew = 1'b0; ed = '0;
    if (ecs) begin
      ea = eg1 ? m1_addr : m0_addr;
      ew = eg1 ? m1_wr_rd : m0_wr_rd;
      ed = eg1 ? m1_wdata : m0_wdata;
    end
    chk({tag, "_m0_gnt"}, {31'b0, m0_gnt}, {31'b0, eg0});
    chk({tag, "_m1_gnt"}, {31'b0, m1_gnt}, {31'b0, eg1});
    chk({tag, "_bus_cs"}, {31'b0, bus_cs}, {31'b0, ecs});
    chk({tag, "_bus_addr"}, bus_addr, ea);
    chk({tag, "_bus_wr_rd"}, {31'b0, bus_wr_rd}, {31'b0, ew});
    chk({tag, "_bus_wdata"}, bus_wdata, ed);
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_wr_rd = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr_rd = 0; m1_addr = '0; m1_wdata = '0;

    //            rst r0 w0 a0        r1 w1 a1        g0 g1 cs
    tbl[0]  = mk(1, 1, 0, 32'h10,  1, 0, 32'h20,  0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 32'h10,  1, 0, 32'h20,  0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 32'h10,  1, 0, 32'h20,  0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 32'h10,  1, 0, 32'h20,  0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 32'h10,  1, 0, 32'h20,  1, 0, 1);
    tbl[5]  = mk(0, 1, 0, 32'h14,  1, 0, 32'h20,  1, 0, 1);
    tbl[6]  = mk(0, 1, 0, 32'h18,  1, 0, 32'h20,  1, 0, 1);
    tbl[7]  = mk(0, 1, 0, 32'h1C,  1, 0, 32'h20,  1, 0, 1);
    tbl[8]  = mk(0, 1, 0, 32'h30,  1, 0, 32'h20,  0, 1, 1);
    tbl[9]  = mk(0, 1, 0, 32'h30,  1, 0, 32'h24,  0, 1, 1);
    tbl[10] = mk(0, 1, 0, 32'h30,  1, 0, 32'h28,  0, 1, 1);
    tbl[11] = mk(0, 1, 0, 32'h30,  1, 0, 32'h2C,  0, 1, 1);
    tbl[12] = mk(0, 1, 0, 32'h30,  1, 0, 32'h40,  1, 0, 1);
    tbl[13] = mk(0, 1, 1, 32'h34,  0, 0, 32'h40,  1, 0, 1);
    tbl[14] = mk(0, 1, 0, 32'h38,  1, 0, 32'h40,  1, 0, 1);
    tbl[15] = mk(0, 0, 0, 32'h3C,  1, 0, 32'h40,  1, 0, 0);
    tbl[16] = mk(0, 0, 0, 32'h3C,  1, 1, 32'h40,  0, 1, 1);
    tbl[17] = mk(0, 0, 0, 32'h3C,  0, 0, 32'h44,  0, 1, 0);
    tbl[18] = mk(0, 1, 0, 32'h200, 0, 0, 32'h44,  0, 0, 0);
    tbl[19] = mk(0, 1, 0, 32'h200, 0, 0, 32'h44,  1, 0, 1);
    tbl[20] = mk(0, 0, 0, 32'h200, 0, 0, 32'h44,  1, 0, 0);
    tbl[21] = mk(0, 0, 0, 32'h204, 0, 0, 32'h44,  0, 0, 0);
    tbl[22] = mk(0, 1, 0, 32'h50,  1, 0, 32'h60,  0, 0, 0);
    tbl[23] = mk(0, 1, 0, 32'h50,  1, 0, 32'h60,  0, 1, 1);
    tbl[24] = mk(0, 1, 0, 32'h50,  0, 0, 32'h64,  0, 1, 0);
    tbl[25] = mk(0, 0, 0, 32'h54,  0, 0, 32'h64,  1, 0, 0);
    tbl[26] = mk(0, 0, 0, 32'h54,  0, 0, 32'h64,  0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < NROWS; i++) begin
      @(posedge clk);
      #1;
      rst      = tbl[i].rst;
      m0_req   = tbl[i].r0;
      m0_wr_rd = tbl[i].w0;
      m0_addr  = tbl[i].a0;
      m0_wdata = 32'hA000_0000 | i;
      m1_req   = tbl[i].r1;
      m1_wr_rd = tbl[i].w1;
      m1_addr  = tbl[i].a1;
      m1_wdata = 32'hB000_0000 | i;
      if (!tbl[i].rst && tbl[i].r0 && !tbl[i].w0 && tbl[i].eg0) q0.push_back(mem_data(tbl[i].a0));
      if (!tbl[i].rst && tbl[i].r1 && !tbl[i].w1 && tbl[i].eg1) q1.push_back(mem_data(tbl[i].a1));
      @(negedge clk);
      cyc_check($sformatf("row%0d", i), tbl[i].eg0, tbl[i].eg1, tbl[i].ecs);
    end

    // Reset one cycle after a read beat: that read must never come back
    @(posedge clk); #1;
    m0_req = 1; m0_wr_rd = 0; m0_addr = 32'h300; m1_req = 0;
    @(negedge clk);
    cyc_check("rstdrop_arb", 0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    cyc_check("rstdrop_beat", 1, 0, 1);
    @(posedge clk); #1;
    rst = 1; m0_req = 0;
    @(negedge clk);
    chk("rstdrop_rv_in_rst", {31'b0, m0_rvalid}, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rstdrop_m0_rvalid%0d", k), {31'b0, m0_rvalid}, 32'h0);
      chk($sformatf("rstdrop_m1_rvalid%0d", k), {31'b0, m1_rvalid}, 32'h0);
      chk($sformatf("rstdrop_gnt%0d", k), {30'b0, m1_gnt, m0_gnt}, 32'h0);
      @(posedge clk); #1;
    end

    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
